command_queue: RTL

COMMAND_QUEUE -- requirements
Module: command_queue

---
 rtl/command_queue.sv | 101 ++++++++++
 1 files changed

// File: rtl/command_queue.sv
// Show-ahead command FIFO between the G-code parser and the motion controller.
// Holds {cmd, x, y} words in a circular buffer; bad codes and full-queue writes raise sticky flags.
module command_queue #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_valid,
  input  logic [3:0]    wr_cmd,
  input  logic [13:0]   wr_x,
  input  logic [13:0]   wr_y,
  output logic          wr_ready,
  input  logic          flush,
  input  logic          block,
  input  logic          controller_ready,
  output logic          memory_ready,
  output logic [3:0]    cmd,
  output logic [13:0]   x_value_in,
  output logic [13:0]   y_value_in,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          bad_cmd
);

  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [3:0]  MAX_CMD    = 4'd8;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          bad_cmd_q, bad_cmd_d;
  logic          cmd_ok;
  logic          push;
  logic          pop;
  logic [31:0]   head_word;

  assign wr_ready     = (count_q != FULL_COUNT);
  assign memory_ready = (count_q != '0);
  assign cmd_ok       = (wr_cmd <= MAX_CMD);

  // Flush cancels any transfer on the same edge, so it gates both strobes.
  assign push = wr_valid & wr_ready & cmd_ok & ~flush;
  assign pop  = memory_ready & controller_ready & ~block & ~flush;

  assign head_word  = memory_ready ? mem[rd_ptr_q] : '0;
  assign cmd        = head_word[31:28];
  assign x_value_in = head_word[27:14];
  assign y_value_in = head_word[13:0];
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign bad_cmd    = bad_cmd_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (wr_valid & ~wr_ready);
    bad_cmd_d  = bad_cmd_q | (wr_valid & wr_ready & ~cmd_ok);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + (AW + 1)'(1);
        2'b01:   count_d = count_q - (AW + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      bad_cmd_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      bad_cmd_q  <= bad_cmd_d;
    end
  end

  // NOTE: the storage array is not reset; count gates every read, so stale words are never visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {wr_cmd, wr_x, wr_y};
  end

endmodule
